// File: rtl/m_ext_issue_ctrl_pkg.sv
// Shared types and defaults for the M-extension issue controller.
// Pending-write entries and source-match helper live here.
package m_ext_issue_ctrl_pkg;

    localparam int REG_SIZE    = 5;
    localparam int M_EXT_LAT   = 5;
    localparam int MAIN_WB_LAT = 2;

    typedef struct packed {
        logic                v;
        logic [REG_SIZE-1:0] rd;
    } pend_entry_t;

    // x0 is hard-wired, so a read of it never depends on an in-flight op
    function automatic logic src_hit(
        input pend_entry_t         e,
        input logic                used,
        input logic [REG_SIZE-1:0] rs
    );
        return e.v & used & (rs != '0) & (e.rd == rs);
    endfunction

endpackage

// File: rtl/m_ext_scoreboard.sv
// Shadow of in-flight M-ext destinations, shifting in lock-step with
// the non-stalling M-ext pipeline; flags RAW, WAW and write-port clashes.
module m_ext_scoreboard
    import m_ext_issue_ctrl_pkg::*;
#(
    parameter int M_LAT   = M_EXT_LAT,
    parameter int MAIN_WB = MAIN_WB_LAT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic [REG_SIZE-1:0] push_rd_i,
    input  logic [REG_SIZE-1:0] rs1_i,
    input  logic [REG_SIZE-1:0] rs2_i,
    input  logic                rs1_used_i,
    input  logic                rs2_used_i,
    input  logic [REG_SIZE-1:0] rd_i,
    input  logic                rd_we_i,
    output logic                raw_o,
    output logic                waw_o,
    output logic                wport_busy_o
);

    pend_entry_t pend_q [1:M_LAT];
    pend_entry_t pend_d [1:M_LAT];

    always_comb begin
        pend_d[1].v  = push_i;
        pend_d[1].rd = push_rd_i;
        for (int k = 2; k <= M_LAT; k++) begin
            pend_d[k] = pend_q[k-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 1; k <= M_LAT; k++) begin
                pend_q[k] <= '0;
            end
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        raw_o = 1'b0;
        waw_o = 1'b0;
        for (int k = 1; k <= M_LAT; k++) begin
            raw_o = raw_o
                  | src_hit(pend_q[k], rs1_used_i, rs1_i)
                  | src_hit(pend_q[k], rs2_used_i, rs2_i);
            waw_o = waw_o
                  | (rd_we_i & (rd_i != '0) & pend_q[k].v
                     & (pend_q[k].rd == rd_i));
        end
    end

    // entry that retires in the same cycle a main op issued now would
    assign wport_busy_o = pend_q[M_LAT-MAIN_WB].v;

endmodule

// File: rtl/m_ext_issue_ctrl.sv
// Decode-side issue steering between the M-ext and main pipelines,
// with hazard stalls and a saturating stall-cycle counter.
module m_ext_issue_ctrl
    import m_ext_issue_ctrl_pkg::*;
#(
    parameter int M_LAT       = M_EXT_LAT,
    parameter int MAIN_WB_LAT = m_ext_issue_ctrl_pkg::MAIN_WB_LAT,
    parameter int CNT_W       = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                dec_valid_i,
    output logic                dec_ready_o,
    input  logic                dec_is_mext_i,
    input  logic [REG_SIZE-1:0] dec_rs1_i,
    input  logic [REG_SIZE-1:0] dec_rs2_i,
    input  logic                dec_rs1_used_i,
    input  logic                dec_rs2_used_i,
    input  logic [REG_SIZE-1:0] dec_rd_i,
    input  logic                dec_rd_we_i,
    input  logic                main_ready_i,
    output logic                issue_m_o,
    output logic                issue_main_o,
    output logic                hazard_o,
    input  logic                clear_cnt_i,
    output logic [CNT_W-1:0]    stall_cnt_o
);

    logic             raw;
    logic             waw;
    logic             wport_busy;
    logic             struct_haz;
    logic             fire;
    logic             push;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    m_ext_scoreboard #(
        .M_LAT   (M_LAT),
        .MAIN_WB (MAIN_WB_LAT)
    ) u_sb (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (push),
        .push_rd_i    (dec_rd_i),
        .rs1_i        (dec_rs1_i),
        .rs2_i        (dec_rs2_i),
        .rs1_used_i   (dec_rs1_used_i),
        .rs2_used_i   (dec_rs2_used_i),
        .rd_i         (dec_rd_i),
        .rd_we_i      (dec_rd_we_i),
        .raw_o        (raw),
        .waw_o        (waw),
        .wport_busy_o (wport_busy)
    );

    assign struct_haz   = !dec_is_mext_i & dec_rd_we_i & wport_busy;
    assign hazard_o     = dec_valid_i & (raw | waw | struct_haz);
    assign dec_ready_o  = !rst_i & !hazard_o
                        & (dec_is_mext_i | main_ready_i);
    assign fire         = dec_valid_i & dec_ready_o;
    assign issue_m_o    = fire & dec_is_mext_i;
    assign issue_main_o = fire & !dec_is_mext_i;
    assign push         = issue_m_o & dec_rd_we_i & (dec_rd_i != '0);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clear_cnt_i) begin
            stall_cnt_d = '0;
        end else if (dec_valid_i & !dec_ready_o
                     & (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule
